serial_add_ctrl: RTL and testbench

//   Bit-serial adder controller: sequences one fulladder cell over WIDTH bit-times
//   to add two WIDTH-bit operands plus carry-in.

---
 rtl/serial_add_ctrl_pkg.sv | 10 +
 rtl/serial_add_ctrl_if.sv | 25 ++
 rtl/serial_add_ctrl_fulladder.sv | 11 +
 rtl/serial_add_ctrl.sv | 106 ++++++++++
 tb/tb_serial_add_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encodings.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder controller.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, busy, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, busy, out_valid, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl_fulladder.sv
// Single-bit full adder cell used as the serial datapath slice.
module serial_add_ctrl_fulladder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice stepped over WIDTH bit-times.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum_out;
  logic             r_cout_out;
  logic             w_fa_s;
  logic             w_fa_c;
  logic             w_accept;
  logic             w_in_ready;
  logic             w_busy;
  logic             w_out_valid;
  logic [WIDTH-1:0] w_sum_shifted;

  serial_add_ctrl_fulladder u_fa (
    .i_a (r_a_sh[0]),
    .i_b (r_b_sh[0]),
    .i_c (r_carry),
    .o_s (w_fa_s),
    .o_c (w_fa_c)
  );

  assign w_accept      = bus.in_valid && w_in_ready;
  assign w_sum_shifted = {w_fa_s, r_sum_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = ST_IDLE;
    w_in_ready   = 1'b0;
    w_busy       = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready   = 1'b1;
        w_state_next = bus.in_valid ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        w_busy       = 1'b1;
        w_state_next = (r_cnt == LAST) ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        w_out_valid  = 1'b1;
        w_state_next = bus.out_ready ? ST_IDLE : ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Result registers update only on the final RUN edge so the visible
  // sum/cout never show partial values and persist across IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_sum_sh   <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_sum_out  <= '0;
      r_cout_out <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= bus.a;
      r_b_sh  <= bus.b;
      r_carry <= bus.cin;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_sum_sh <= w_sum_shifted;
      r_carry  <= w_fa_c;
      r_cnt    <= r_cnt + CW'(1);
      if (r_cnt == LAST) begin
        r_sum_out  <= w_sum_shifted;
        r_cout_out <= w_fa_c;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = w_busy;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = r_sum_out;
  assign bus.cout      = r_cout_out;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and sweep bench for serial_add_ctrl at WIDTH=8 and WIDTH=4.
module tb_serial_add_ctrl;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_add_ctrl_if #(.WIDTH(4)) bus4 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_add_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready8();
    int n = 0;
    while (!bus8.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_idle", 32'(bus8.in_ready), 32'd1);
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    wait_ready8();
    bus8.a        = a;
    bus8.b        = b;
    bus8.cin      = cin;
    bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    chk("busy_after_accept", 32'(bus8.busy), 32'd1);
    chk("in_ready_in_run", 32'(bus8.in_ready), 32'd0);
  endtask

  task automatic wait_done8();
    int n = 0;
    while (!bus8.out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("latency8", 32'(n), 32'd8);
  endtask

  task automatic handshake8();
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
    chk("in_ready_after_hs", 32'(bus8.in_ready), 32'd1);
    chk("out_valid_after_hs", 32'(bus8.out_valid), 32'd0);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic [7:0] es, input logic ec);
    start8(a, b, cin);
    wait_done8();
    chk("sum8", 32'(bus8.sum), 32'(es));
    chk("cout8", 32'(bus8.cout), 32'(ec));
    $display("op8 a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d (exp %02h/%0d)",
             a, b, cin, bus8.sum, bus8.cout, es, ec);
    handshake8();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.out_ready = 1'b0;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    vecs[7] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};

    #2;
    chk("rst_in_ready", 32'(bus8.in_ready), 32'd1);
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("rst_sum", 32'(bus8.sum), 32'd0);
    chk("rst_cout", 32'(bus8.cout), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout);
    end

    // Backpressure in DONE while in_valid toggles with other operands.
    start8(8'h0F, 8'h01, 1'b0);
    wait_done8();
    for (int k = 0; k < 5; k++) begin
      bus8.a        = 8'h33;
      bus8.b        = 8'h44;
      bus8.in_valid = ~bus8.in_valid;
      tick();
      chk("stall_out_valid", 32'(bus8.out_valid), 32'd1);
      chk("stall_in_ready", 32'(bus8.in_ready), 32'd0);
      chk("stall_sum", 32'(bus8.sum), 32'h10);
      chk("stall_cout", 32'(bus8.cout), 32'd0);
    end
    bus8.in_valid = 1'b0;
    $display("stall held sum=%02h cout=%0d for 5 cycles", bus8.sum, bus8.cout);
    handshake8();
    chk("no_accept_in_done", 32'(bus8.busy), 32'd0);

    // Reset in the 3rd RUN cycle abandons the op.
    start8(8'h33, 8'h44, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(bus8.in_ready), 32'd1);
    chk("midrst_busy", 32'(bus8.busy), 32'd0);
    chk("midrst_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("midrst_sum", 32'(bus8.sum), 32'd0);
    chk("midrst_cout", 32'(bus8.cout), 32'd0);
    $display("mid-run reset applied sum=%02h busy=%0d", bus8.sum, bus8.busy);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    op8(8'h55, 8'hAA, 1'b1, 8'h00, 1'b1);

    // Back-to-back with in_valid and out_ready held high.
    begin
      int last_c;
      int n_res;
      logic prev_hs;
      last_c  = -1;
      n_res   = 0;
      prev_hs = 1'b0;
      bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b1;
      bus8.in_valid  = 1'b1;
      bus8.out_ready = 1'b1;
      for (int c = 0; c < 45; c++) begin
        tick();
        if (prev_hs) chk("b2b_in_ready_after_hs", 32'(bus8.in_ready), 32'd1);
        prev_hs = bus8.out_valid;
        if (bus8.out_valid) begin
          chk("b2b_sum", 32'(bus8.sum), 32'h47);
          if (last_c >= 0) chk("b2b_interval", 32'(c - last_c), 32'd10);
          $display("b2b result %0d at cycle %0d sum=%02h", n_res, c, bus8.sum);
          last_c = c;
          n_res++;
        end
      end
      chk("b2b_result_count_ge3", 32'(n_res >= 3), 32'd1);
      bus8.in_valid  = 1'b0;
      repeat (12) tick();
      bus8.out_ready = 1'b0;
    end

    // WIDTH=4 exhaustive sweep with random result stalls.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] iv;
      logic [4:0] exp5;
      int n;
      iv   = 9'(i);
      exp5 = 5'(iv[3:0]) + 5'(iv[7:4]) + 5'(iv[8]);
      n = 0;
      while (!bus4.in_ready && n < 50) begin
        tick();
        n++;
      end
      bus4.a = iv[3:0]; bus4.b = iv[7:4]; bus4.cin = iv[8];
      bus4.in_valid = 1'b1;
      tick();
      bus4.in_valid = 1'b0;
      n = 0;
      while (!bus4.out_valid && n < 50) begin
        tick();
        n++;
      end
      chk("latency4", 32'(n), 32'd4);
      repeat ($urandom_range(0, 3)) tick();
      chk("sum4", 32'({bus4.cout, bus4.sum}), 32'(exp5));
      $display("op4 a=%0h b=%0h cin=%0d -> cout,sum=%02h (exp %02h)",
               iv[3:0], iv[7:4], iv[8], {bus4.cout, bus4.sum}, exp5);
      bus4.out_ready = 1'b1;
      tick();
      bus4.out_ready = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
